// File: rtl/hdlc_pkg.sv
// -----------------------------------------------------------------------------
// hdlc_pkg
// Shared definitions for the Hdlc receive-side register consumer:
//   - Hdlc register addresses (Rx_SC, Rx_Buff, Rx_Len)
//   - Rx_SC bit positions
//   - err_code_t   : drop reason reported on ErrCode
//   - fetch_state_t: hdlc_rx_fetch FSM states
//   - sc_err_code(): maps an Rx_SC error bit pattern to a drop reason
// -----------------------------------------------------------------------------
package hdlc_pkg;

   localparam logic [2:0] RX_SC   = 3'd2;
   localparam logic [2:0] RX_BUFF = 3'd3;
   localparam logic [2:0] RX_LEN  = 3'd4;

   localparam int SC_READY = 0;
   localparam int SC_DROP  = 1;
   localparam int SC_FERR  = 2;
   localparam int SC_ABORT = 3;
   localparam int SC_OVF   = 4;
   localparam int SC_FCSEN = 5;

   typedef enum logic [2:0] {
      ERR_NONE  = 3'd0,
      ERR_FRAME = 3'd1,
      ERR_ABORT = 3'd2,
      ERR_OVF   = 3'd3,
      ERR_LEN   = 3'd4
   } err_code_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CFG,
      S_GAP,
      S_POLL,
      S_SC_WAIT,
      S_LEN,
      S_LEN_WAIT,
      S_DROP,
      S_RD,
      S_RD_WAIT,
      S_HOLD,
      S_DONE
   } fetch_state_t;

   // Highest-priority error wins: FrameError > Abort > Overflow.
   function automatic err_code_t sc_err_code(input logic [7:0] sc);
      if (sc[SC_FERR])       return ERR_FRAME;
      else if (sc[SC_ABORT]) return ERR_ABORT;
      else if (sc[SC_OVF])   return ERR_OVF;
      else                   return ERR_NONE;
   endfunction

endpackage

// File: rtl/hdlc_rx_fetch.sv
// -----------------------------------------------------------------------------
// hdlc_rx_fetch
// Host-side consumer of the Hdlc register bus. Periodically polls Rx_SC; when a
// frame is ready it reads Rx_Len and drains Rx_Buff one byte at a time, handing
// each byte out on a valid/ready stream (m_last marks the final byte). Frames
// flagged with FrameError/Abort/Overflow, or with an illegal length, are
// discarded by writing the Drop bit of Rx_SC and reported on FrameErr/ErrCode.
//
// Parameters
//   POLL_GAP   idle cycles between consecutive Rx_SC polls (>=1)
//   MAX_FRAME  largest legal Rx_Len; zero or larger is a length error
//
// Ports
//   Clk, Rst         clock; synchronous active-low reset
//   Enable           allow polling for new frames (a frame in progress finishes)
//   FCSen            value placed on Rx_SC bit5 in every Rx_SC write
//   Address, WriteEnable, ReadEnable, DataIn, DataOut   Hdlc register bus
//   m_data, m_valid, m_ready, m_last                    output byte stream
//   FrameDone        one-cycle pulse after the last byte is accepted
//   FrameErr, ErrCode one-cycle pulse + reason when a frame is dropped
//
// Build option
//   HDLC_RX_FETCH_STATS_EN : adds saturating FrameCnt / ErrCnt outputs.
// -----------------------------------------------------------------------------
module hdlc_rx_fetch
   import hdlc_pkg::*;
#(
   parameter int POLL_GAP  = 16,
   parameter int MAX_FRAME = 126
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Enable,
   input  logic        FCSen,
   output logic [2:0]  Address,
   output logic        WriteEnable,
   output logic        ReadEnable,
   output logic [7:0]  DataIn,
   input  logic [7:0]  DataOut,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic        FrameDone,
   output logic        FrameErr,
`ifdef HDLC_RX_FETCH_STATS_EN
   output logic [15:0] FrameCnt,
   output logic [15:0] ErrCnt,
`endif
   output logic [2:0]  ErrCode
);

   localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
   localparam logic [7:0]  MAX_LEN  = 8'(MAX_FRAME);

   fetch_state_t state_q, state_d;
   logic [15:0]  gap_q,   gap_d;
   logic [7:0]   len_q,   len_d;
   logic [7:0]   idx_q,   idx_d;
   logic [7:0]   data_q,  data_d;
   err_code_t    err_q,   err_d;

   logic [7:0]   sc_base;
   logic         is_last;

   // Every Rx_SC write carries the current FCSen in bit5.
   assign sc_base = {2'b00, FCSen, 5'b00000};
   assign is_last = (idx_q == len_q - 8'd1);
   assign m_data  = data_q;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         gap_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      gap_d       = gap_q;
      len_d       = len_q;
      idx_d       = idx_q;
      data_d      = data_q;
      err_d       = err_q;
      Address     = '0;
      WriteEnable = 1'b0;
      ReadEnable  = 1'b0;
      DataIn      = '0;
      m_valid     = 1'b0;
      m_last      = 1'b0;
      FrameDone   = 1'b0;
      FrameErr    = 1'b0;
      ErrCode     = '0;

      case (state_q)
         S_IDLE: begin
            if (Enable) state_d = S_CFG;
         end

         S_CFG: begin
            WriteEnable = 1'b1;
            Address     = RX_SC;
            DataIn      = sc_base;
            gap_d       = '0;
            state_d     = S_GAP;
         end

         // Counter saturates at the last gap cycle and waits there for Enable.
         S_GAP: begin
            if (gap_q != GAP_LAST) gap_d = gap_q + 16'd1;
            else if (Enable)        state_d = S_POLL;
         end

         S_POLL: begin
            ReadEnable = 1'b1;
            Address    = RX_SC;
            state_d    = S_SC_WAIT;
         end

         S_SC_WAIT: begin
            if (!DataOut[SC_READY]) begin
               gap_d   = '0;
               state_d = S_GAP;
            end else if (DataOut[SC_OVF:SC_FERR] != 3'b000) begin
               err_d   = sc_err_code(DataOut);
               state_d = S_DROP;
            end else begin
               state_d = S_LEN;
            end
         end

         S_LEN: begin
            ReadEnable = 1'b1;
            Address    = RX_LEN;
            state_d    = S_LEN_WAIT;
         end

         S_LEN_WAIT: begin
            len_d = DataOut;
            idx_d = '0;
            if (DataOut == 8'd0 || DataOut > MAX_LEN) begin
               err_d   = ERR_LEN;
               state_d = S_DROP;
            end else begin
               state_d = S_RD;
            end
         end

         S_DROP: begin
            WriteEnable = 1'b1;
            Address     = RX_SC;
            DataIn      = sc_base | 8'h02;
            FrameErr    = 1'b1;
            ErrCode     = err_q;
            gap_d       = '0;
            state_d     = S_GAP;
         end

         S_RD: begin
            ReadEnable = 1'b1;
            Address    = RX_BUFF;
            state_d    = S_RD_WAIT;
         end

         S_RD_WAIT: begin
            data_d  = DataOut;
            state_d = S_HOLD;
         end

         // Byte held here until accepted; no bus activity meanwhile.
         S_HOLD: begin
            m_valid = 1'b1;
            m_last  = is_last;
            if (m_ready) begin
               idx_d   = idx_q + 8'd1;
               state_d = is_last ? S_DONE : S_RD;
            end
         end

         S_DONE: begin
            FrameDone = 1'b1;
            gap_d     = '0;
            state_d   = S_GAP;
         end

         default: state_d = S_IDLE;
      endcase
   end

`ifdef HDLC_RX_FETCH_STATS_EN
   logic [15:0] frame_cnt_q, err_cnt_q;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         if (state_q == S_DONE && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (state_q == S_DROP && err_cnt_q   != 16'hFFFF) err_cnt_q   <= err_cnt_q + 16'd1;
      end
   end

   assign FrameCnt = frame_cnt_q;
   assign ErrCnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_hdlc_rx_fetch.sv
// -----------------------------------------------------------------------------
// tb_hdlc_rx_fetch
// Bench for hdlc_rx_fetch with a behavioural Hdlc register model. Directed
// frames push expected bytes and frame events into queues; a monitor process
// pops and compares whenever the DUT presents a byte, FrameDone or FrameErr,
// and checks every bus write.
// -----------------------------------------------------------------------------
module tb_hdlc_rx_fetch;

   localparam int MAXF = 126;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       Enable = 1'b0;
   logic       FCSen = 1'b1;
   logic       m_ready = 1'b1;
   logic [2:0] Address;
   logic       WriteEnable, ReadEnable;
   logic [7:0] DataIn;
   logic [7:0] DataOut = 8'h00;
   logic [7:0] m_data;
   logic       m_valid, m_last, FrameDone, FrameErr;
   logic [2:0] ErrCode;
`ifdef HDLC_RX_FETCH_STATS_EN
   logic [15:0] FrameCnt, ErrCnt;
`endif

   always #5 Clk = ~Clk;

   hdlc_rx_fetch #(.POLL_GAP(16), .MAX_FRAME(MAXF)) dut (
      .Clk(Clk), .Rst(Rst), .Enable(Enable), .FCSen(FCSen),
      .Address(Address), .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
      .DataIn(DataIn), .DataOut(DataOut),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .FrameDone(FrameDone), .FrameErr(FrameErr),
`ifdef HDLC_RX_FETCH_STATS_EN
      .FrameCnt(FrameCnt), .ErrCnt(ErrCnt),
`endif
      .ErrCode(ErrCode)
   );

   // ---------------- Hdlc register model ----------------
   logic [7:0] sc_reg = 8'h00;
   logic [7:0] len_reg = 8'h00;
   logic [7:0] buff [0:255];
   int frame_base = 0;
   int sc_reads = 0, len_reads = 0, buff_reads = 0;

   always @(posedge Clk) begin
      if (ReadEnable) begin
         case (Address)
            3'd2: begin DataOut <= sc_reg;  sc_reads <= sc_reads + 1; end
            3'd4: begin DataOut <= len_reg; len_reads <= len_reads + 1; end
            3'd3: begin
               DataOut    <= buff[8'(buff_reads - frame_base)];
               buff_reads <= buff_reads + 1;
            end
            default: DataOut <= 8'hEE;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed { logic [7:0] d; logic l; } exp_t;
   exp_t exp_q[$];
   int   ev_q[$];          // 0 = FrameDone, 1..4 = expected ErrCode
   int   asserts = 0, fails = 0;
   int   bytes_seen = 0, ev_seen = 0, drop_wr = 0, cfg_wr = 0;
   int   stall_n = 0;

   function automatic void check(input string name, input int act, input int exp);
      asserts++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endfunction

   // Sink: m_ready low for stall_n cycles of each presented byte.
   initial begin
      int wcnt;
      wcnt = 0;
      forever begin
         @(negedge Clk);
         if (stall_n == 0) m_ready = 1'b1;
         else if (m_valid) begin
            if (wcnt >= stall_n) begin m_ready = 1'b1; wcnt = 0; end
            else begin m_ready = 1'b0; wcnt++; end
         end else begin
            m_ready = 1'b0;
            wcnt    = 0;
         end
      end
   end

   // Monitor
   initial begin
      logic       pv, pr, pl;
      logic [7:0] pd;
      exp_t       e;
      int         k;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
      forever begin
         @(negedge Clk);
         #1;
         if (Rst) begin
            if (ReadEnable || WriteEnable) check("bus_rd_wr_same_cycle", int'(ReadEnable && WriteEnable), 0);
            if (WriteEnable) begin
               check("wr_addr", Address, 2);
               if (DataIn[1]) begin
                  drop_wr++;
                  check("drop_data", DataIn, {2'b00, FCSen, 5'b00010});
               end else begin
                  cfg_wr++;
                  check("cfg_data", DataIn, {2'b00, FCSen, 5'b00000});
               end
            end
            if (pv && !pr && m_valid) begin
               check("stall_data", m_data, pd);
               check("stall_last", m_last, pl);
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) check("unexpected_byte", m_data, -1);
               else begin
                  e = exp_q.pop_front();
                  check("byte_data", m_data, e.d);
                  check("byte_last", m_last, e.l);
               end
               bytes_seen++;
            end
            if (FrameDone || FrameErr) begin
               if (ev_q.size() == 0) check("unexpected_event", {FrameDone, FrameErr}, 0);
               else begin
                  k = ev_q.pop_front();
                  check("event_done", FrameDone, k == 0);
                  check("event_err", FrameErr, k != 0);
                  if (FrameErr) check("err_code", ErrCode, k);
               end
               ev_seen++;
            end
         end
         pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      end
   end

   // ---------------- driver ----------------
   task automatic wait_ev(input string name, input int target, input int maxc);
      int n = 0;
      while (ev_seen < target && n < maxc) begin @(negedge Clk); n++; end
      check({name, "_event_seen"}, int'(ev_seen >= target), 1);
   endtask

   task automatic check_reset_outs(input string p);
      check({p, "_Address"}, Address, 0);
      check({p, "_DataIn"}, DataIn, 0);
      check({p, "_ReadEnable"}, ReadEnable, 0);
      check({p, "_WriteEnable"}, WriteEnable, 0);
      check({p, "_m_valid"}, m_valid, 0);
      check({p, "_m_last"}, m_last, 0);
      check({p, "_FrameDone"}, FrameDone, 0);
      check({p, "_FrameErr"}, FrameErr, 0);
      check({p, "_ErrCode"}, ErrCode, 0);
`ifdef HDLC_RX_FETCH_STATS_EN
      check({p, "_FrameCnt"}, FrameCnt, 0);
      check({p, "_ErrCnt"}, ErrCnt, 0);
`endif
   endtask

   // kind 0: frame of len bytes from buff expected; kind 1..4: drop expected.
   task automatic run_frame(input string name, input logic [7:0] sc, input logic [7:0] len, input int kind);
      int b_br = buff_reads;
      int b_dw = drop_wr;
      int tgt  = ev_seen + 1;
      int nb   = (kind == 0) ? int'(len) : 0;
      for (int i = 0; i < nb; i++) exp_q.push_back('{d: buff[i], l: (i == nb - 1)});
      ev_q.push_back(kind);
      frame_base = buff_reads;
      len_reg    = len;
      sc_reg     = sc;
      wait_ev(name, tgt, 200 + nb * 40);
      sc_reg = 8'h00;
      check({name, "_buff_reads"}, buff_reads - b_br, nb);
      check({name, "_drop_writes"}, drop_wr - b_dw, (kind != 0) ? 1 : 0);
      check({name, "_bytes_left"}, exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int b, sr, es, n;

      // Reset
      repeat (3) @(negedge Clk);
      check_reset_outs("reset");
      Rst = 1'b1;
      repeat (5) @(negedge Clk);
      check("idle_no_cfg_without_enable", cfg_wr, 0);
      Enable = 1'b1;
      repeat (3) @(negedge Clk);
      check("cfg_write_once", cfg_wr, 1);

      // 1: basic 3-byte frame
      buff[0] = 8'hAA; buff[1] = 8'h55; buff[2] = 8'h0F;
      run_frame("t1_basic", 8'h01, 8'd3, 0);

      // 2: same frame, sink stalls 10 cycles per byte
      stall_n = 10;
      run_frame("t2_stall", 8'h01, 8'd3, 0);
      stall_n = 0;

      // 3: abort, plus error priority cases
      run_frame("t3_abort", 8'h09, 8'd3, 2);
      run_frame("t3_prio_all", 8'h1D, 8'd3, 1);
      run_frame("t3_ovf", 8'h11, 8'd3, 3);
      check("t3_no_len_reads_on_sc_err", len_reads, 2);

      // 4: length boundaries
      run_frame("t4_len0", 8'h01, 8'd0, 4);
      run_frame("t4_len_max_plus1", 8'h01, 8'(MAXF + 1), 4);
      for (int i = 0; i < MAXF; i++) buff[i] = 8'(i) ^ 8'hA5;
      run_frame("t4_len_max", 8'h01, 8'(MAXF), 0);

      // 5: Enable drops during byte 2 of a 4-byte frame
      buff[0] = 8'h11; buff[1] = 8'h22; buff[2] = 8'h33; buff[3] = 8'h44;
      for (int i = 0; i < 4; i++) exp_q.push_back('{d: buff[i], l: (i == 3)});
      ev_q.push_back(0);
      es = ev_seen;
      b  = bytes_seen;
      frame_base = buff_reads; len_reg = 8'd4; sc_reg = 8'h01;
      n = 0;
      while (bytes_seen < b + 1 && n < 500) begin @(negedge Clk); n++; end
      check("t5_first_byte_seen", int'(bytes_seen >= b + 1), 1);
      Enable = 1'b0;
      wait_ev("t5_frame", es + 1, 300);
      sc_reg = 8'h00;
      check("t5_all_bytes", bytes_seen - b, 4);
      buff[0] = 8'h5A;
      frame_base = buff_reads; len_reg = 8'd1;
      sr = sc_reads;
      sc_reg = 8'h01;
      repeat (100) @(negedge Clk);
      check("t5_no_poll_while_disabled", sc_reads - sr, 0);
      check("t5_no_event_while_disabled", ev_seen, es + 1);
      exp_q.push_back('{d: 8'h5A, l: 1'b1});
      ev_q.push_back(0);
      Enable = 1'b1;
      wait_ev("t5_resume", es + 2, 300);
      sc_reg = 8'h00;

      // 6: reset while holding a byte
      stall_n = 1000;
      buff[0] = 8'h01; buff[1] = 8'h02; buff[2] = 8'h03;
      frame_base = buff_reads; len_reg = 8'd3; sc_reg = 8'h01;
      n = 0;
      while (!m_valid && n < 200) begin @(negedge Clk); n++; end
      check("t6_reached_hold", m_valid, 1);
      b = drop_wr;
      Rst = 1'b0;
      @(negedge Clk);
      check_reset_outs("t6_reset");
      check("t6_no_drop_write", drop_wr, b);
      sc_reg  = 8'h00;
      stall_n = 0;
      repeat (2) @(negedge Clk);
      b = cfg_wr;
      Rst = 1'b1;
      repeat (3) @(negedge Clk);
      check("t6_cfg_after_reset", cfg_wr - b, 1);
      buff[0] = 8'hC3; buff[1] = 8'h3C;
      run_frame("t6_recover", 8'h01, 8'd2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
